seq_divider: RTL and testbench

//   Iterative unsigned restoring divider, the inverse operation of the 4-bit array multiplier.

---
 rtl/seq_div_pkg.sv | 6 +
 rtl/seq_divider_div_step.sv | 23 ++
 rtl/seq_divider.sv | 91 +++++++++
 tb/tb_seq_divider.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
`timescale 100ps/1ps
// seq_div_pkg: shared state encoding and default operand width for the sequential divider
package seq_div_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/seq_divider_div_step.sv
`timescale 100ps/1ps
// div_step: one combinational restoring-division step on the {acc,q} pair
module div_step
   import seq_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] acc_next,
   output logic [WIDTH-1:0] q_next
);
   logic [WIDTH:0] shifted;
   logic           ge;
   // acc < d always holds, so the subtracted value fits back into WIDTH bits
   always_comb begin
      shifted  = {acc, q[WIDTH-1]};
      ge       = shifted >= {1'b0, d};
      acc_next = shifted[WIDTH-1:0] - (ge ? d : '0);
      q_next   = {q[WIDTH-2:0], ge};
   end
endmodule

// File: rtl/seq_divider.sv
`timescale 100ps/1ps
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock.
// Optional SEQ_DIV_ZERO_SHORTCUT_EN: a zero divisor jumps straight from IDLE to DONE.
module seq_divider
   import seq_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] acc, q, d, acc_next, q_next;
   logic [CW-1:0]    cnt;

   div_step #(.WIDTH(WIDTH)) step (
      .acc(acc),
      .q(q),
      .d(d),
      .acc_next(acc_next),
      .q_next(q_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         acc         <= '0;
         q           <= '0;
         d           <= '0;
         cnt         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               acc         <= '0;
               q           <= dividend;
               d           <= divisor;
               cnt         <= '0;
               busy        <= 1'b1;
               div_by_zero <= 1'b0;
`ifdef SEQ_DIV_ZERO_SHORTCUT_EN
               if (divisor == '0) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  quotient    <= '1;
                  remainder   <= dividend;
                  div_by_zero <= 1'b1;
               end else begin
                  state <= CALC;
               end
`else
               state <= CALC;
`endif
            end
            CALC: begin
               acc <= acc_next;
               q   <= q_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  quotient    <= q_next;
                  remainder   <= acc_next;
                  div_by_zero <= d == '0;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
`timescale 100ps/1ps
// tb_seq_divider: vector table, corner-case sequences and exhaustive sweep checked through a result scoreboard
module tb_seq_divider;
   import seq_div_pkg::*;
   localparam int W = DEF_WIDTH;

   typedef struct {
      logic [W-1:0] a, b, q, r;
      logic         z;
   } vec_t;

   logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [W-1:0] dividend = '0, divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;
   int           tests = 0, fails = 0;
   vec_t         sb[$];
   vec_t         vecs[6];

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      vec_t v;
      v.a = a;
      v.b = b;
      v.q = (b == 0) ? '1 : a / b;
      v.r = (b == 0) ? a : a % b;
      v.z = b == 0;
      return v;
   endfunction

   // edges after the accepting edge until done is visible
   function automatic int lat(input logic [W-1:0] b);
      int shortcut;
`ifdef SEQ_DIV_ZERO_SHORTCUT_EN
      shortcut = 1;
`else
      shortcut = 0;
`endif
      return (b == 0 && shortcut == 1) ? 0 : W;
   endfunction

   task automatic await_done(input int exp_lat);
      int   n = 0;
      vec_t e;
      while (!done && n < 3 * W) begin
         chk("busy_calc", int'(busy), 1);
         @(negedge clk);
         n++;
      end
      chk("done_seen", int'(done), 1);
      chk("latency", n, exp_lat);
      chk("busy_done", int'(busy), 1);
      if (done) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: got done with empty queue required an expected entry");
         end else begin
            e = sb.pop_front();
            chk("quotient", int'(quotient), int'(e.q));
            chk("remainder", int'(remainder), int'(e.r));
            chk("div_by_zero", int'(div_by_zero), int'(e.z));
            if (e.b != 0) begin
               chk("reconstruct", int'(quotient) * int'(e.b) + int'(remainder), int'(e.a));
               chk("rem_lt_div", int'(remainder < e.b), 1);
            end
         end
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1;
      dividend = a;
      divisor = b;
      sb.push_back(model(a, b));
      @(negedge clk);
      start = 1'b0;
      await_done(lat(b));
      @(negedge clk);
      chk("busy_idle", int'(busy), 0);
      chk("done_pulse", int'(done), 0);
   endtask

   initial begin
      int dcount;
      vecs[0] = '{a: 4'd13, b: 4'd3, q: 4'd4, r: 4'd1, z: 1'b0};
      vecs[1] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0, z: 1'b0};
      vecs[2] = '{a: 4'd2, b: 4'd9, q: 4'd0, r: 4'd2, z: 1'b0};
      vecs[3] = '{a: 4'd7, b: 4'd0, q: 4'd15, r: 4'd7, z: 1'b1};
      vecs[4] = '{a: 4'd0, b: 4'd5, q: 4'd0, r: 4'd0, z: 1'b0};
      vecs[5] = '{a: 4'd15, b: 4'd15, q: 4'd1, r: 4'd0, z: 1'b0};

      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_q", int'(quotient), 0);
      chk("rst_r", int'(remainder), 0);
      chk("rst_dbz", int'(div_by_zero), 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start = 1'b1;
         dividend = vecs[i].a;
         divisor = vecs[i].b;
         sb.push_back(vecs[i]);
         @(negedge clk);
         start = 1'b0;
         await_done(lat(vecs[i].b));
         @(negedge clk);
         chk("vec_busy_idle", int'(busy), 0);
      end

      run_op(4'd2, 4'd9);
      dividend = 4'd15;
      divisor = 4'd1;
      repeat (3) @(negedge clk);
      chk("hold_q", int'(quotient), 0);
      chk("hold_r", int'(remainder), 2);
      chk("hold_done", int'(done), 0);

      @(negedge clk);
      start = 1'b1;
      dividend = 4'd9;
      divisor = 4'd2;
      sb.push_back(model(4'd9, 4'd2));
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      dividend = 4'd1;
      divisor = 4'd1;
      @(negedge clk);
      start = 1'b0;
      await_done(W - 2);
      dcount = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("ignored_start_no_done", dcount, 0);
      chk("sb_empty", sb.size(), 0);

      run_op(4'd7, 4'd0);
      @(negedge clk);
      start = 1'b1;
      dividend = 4'd9;
      divisor = 4'd2;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_q", int'(quotient), 0);
      chk("abort_r", int'(remainder), 0);
      chk("abort_dbz", int'(div_by_zero), 0);
      dcount = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("abort_no_done", dcount, 0);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run_op(W'(a), W'(b));
      chk("sweep_sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
